// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM burst-write engine.
//   sdram_cmd_e : SDRAM command encodings {CS#,RAS#,CAS#,WE#}
//   wr_state_e  : write-engine FSM states
//   WAIT_W      : width of the shared tRCD/tWR/tRP wait counter
package sdram_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0111,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_BST = 4'b0110,
    CMD_PRE = 4'b0010
  } sdram_cmd_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACT,
    ST_TRCD,
    ST_WRITE,
    ST_DATA,
    ST_TWR,
    ST_PRE,
    ST_TRP,
    ST_END
  } wr_state_e;

  localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/sdram_wait_cnt.sv
// Loadable down-counter used for the tRCD, tWR and tRP waits.
//   clk      : clock
//   rst      : synchronous active-high reset
//   load     : load load_val on the next edge (takes priority over counting)
//   load_val : number of cycles the wait lasts, counted from the loaded cycle
//   done     : high in the last cycle of the wait (count == 1)
module sdram_wait_cnt
  import sdram_pkg::*;
#(
  parameter int unsigned CNT_W = WAIT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/sdram_write_burst.sv
// SDRAM burst-write engine: ACT / WR / BST / PRE sequencing with per-beat
// byte masks, tWR recovery and automatic splitting at row boundaries.
//   wr_clk, wr_rst         : clock, synchronous active-high reset
//   init_end               : SDRAM initialised; requests ignored while low
//   wr_en                  : write request, sampled in IDLE
//   wr_addr, wr_bst_len    : linear start address {bank,row,col}, beat count
//   wr_data, wr_mask       : beat data / byte mask, consumed when wr_ack is high
//   wr_ack                 : beat consumed this cycle (combinational)
//   wr_busy, wr_end        : busy from acceptance to done, one-cycle done pulse
//   wr_sdram_en            : arbiter bus-drive enable, high on data-beat cycles
//   wr_sdram_cmd/bank/addr : registered SDRAM command bus
//   wr_sdram_data/dqm      : registered DQ / DQM
module sdram_write_burst
  import sdram_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned BANK_W = 2,
  parameter int unsigned ROW_W  = 13,
  parameter int unsigned COL_W  = 9,
  parameter int unsigned LEN_W  = 10,
  parameter int unsigned T_RCD  = 2,
  parameter int unsigned T_WR   = 2,
  parameter int unsigned T_RP   = 2
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic                          init_end,
  input  logic                          wr_en,
  input  logic [BANK_W+ROW_W+COL_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]              wr_bst_len,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [DATA_W/8-1:0]           wr_mask,
  output logic                          wr_ack,
  output logic                          wr_busy,
  output logic                          wr_end,
  output logic                          wr_sdram_en,
  output logic [3:0]                    wr_sdram_cmd,
  output logic [BANK_W-1:0]             wr_sdram_bank,
  output logic [ROW_W-1:0]              wr_sdram_addr,
  output logic [DATA_W-1:0]             wr_sdram_data,
  output logic [DATA_W/8-1:0]           wr_sdram_dqm
);

  localparam int unsigned ADDR_W = BANK_W + ROW_W + COL_W;
  localparam int unsigned SEG_W  = LEN_W + COL_W + 1;

  wr_state_e         state;
  logic [ADDR_W-1:0] ptr;     // start address of the current segment
  logic [LEN_W-1:0]  rem;     // beats not yet covered by a completed segment
  logic [LEN_W-1:0]  seg;     // beats in the current segment
  logic [LEN_W-1:0]  ld_cnt;  // beats still to be acked in the current segment

  logic              wt_load;
  logic [WAIT_W-1:0] wt_val;
  logic              wt_done;
  logic              ld_go;

  logic [BANK_W-1:0] in_bank, ptr_bank;
  logic [ROW_W-1:0]  in_row, ptr_row;
  logic [COL_W-1:0]  in_col, ptr_col;
  logic [LEN_W-1:0]  in_seg, ptr_seg;

  // Beats that fit before the end of the row starting at col.
  function automatic logic [LEN_W-1:0] calc_seg(input logic [COL_W-1:0] col,
                                                input logic [LEN_W-1:0] len);
    logic [SEG_W-1:0] room;
    room = (SEG_W'(1) << COL_W) - SEG_W'(col);
    if (SEG_W'(len) < room) return len;
    return room[LEN_W-1:0];
  endfunction

  assign in_bank  = wr_addr[ADDR_W-1 -: BANK_W];
  assign in_row   = wr_addr[COL_W +: ROW_W];
  assign in_col   = wr_addr[COL_W-1:0];
  assign ptr_bank = ptr[ADDR_W-1 -: BANK_W];
  assign ptr_row  = ptr[COL_W +: ROW_W];
  assign ptr_col  = ptr[COL_W-1:0];
  assign in_seg   = calc_seg(in_col, wr_bst_len);
  assign ptr_seg  = calc_seg(ptr_col, rem);

  // Beat loading starts one cycle before WR so beat 0 lands on the bus with WR.
  always_comb begin
    ld_go = 1'b0;
    case (state)
      ST_ACT:            ld_go = (T_RCD == 1);
      ST_TRCD:           ld_go = wt_done;
      ST_WRITE, ST_DATA: ld_go = 1'b1;
      default:           ld_go = 1'b0;
    endcase
  end

  assign wr_ack = ld_go && (ld_cnt != '0);

  // Wait counter is loaded on the edge entering each wait phase.
  always_comb begin
    wt_load = 1'b0;
    wt_val  = '0;
    case (state)
      ST_ACT: begin
        if (T_RCD > 1) begin
          wt_load = 1'b1;
          wt_val  = WAIT_W'(T_RCD - 1);
        end
      end
      ST_WRITE, ST_DATA: begin
        if (ld_cnt == '0) begin
          wt_load = 1'b1;
          wt_val  = WAIT_W'(T_WR);
        end
      end
      ST_PRE: begin
        if (T_RP > 1) begin
          wt_load = 1'b1;
          wt_val  = WAIT_W'(T_RP - 1);
        end
      end
      default: ;
    endcase
  end

  sdram_wait_cnt #(
    .CNT_W (WAIT_W)
  ) u_wait (
    .clk      (wr_clk),
    .rst      (wr_rst),
    .load     (wt_load),
    .load_val (wt_val),
    .done     (wt_done)
  );

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      rem           <= '0;
      seg           <= '0;
      ld_cnt        <= '0;
      wr_busy       <= 1'b0;
      wr_end        <= 1'b0;
      wr_sdram_en   <= 1'b0;
      wr_sdram_cmd  <= CMD_NOP;
      wr_sdram_bank <= '1;
      wr_sdram_addr <= '1;
      wr_sdram_data <= '0;
      wr_sdram_dqm  <= '1;
    end else begin
      wr_end        <= 1'b0;
      wr_sdram_cmd  <= CMD_NOP;
      wr_sdram_bank <= '1;
      wr_sdram_addr <= '1;
      wr_sdram_en   <= 1'b0;
      wr_sdram_data <= '0;
      wr_sdram_dqm  <= '1;

      if (wr_ack) begin
        wr_sdram_en   <= 1'b1;
        wr_sdram_data <= wr_data;
        wr_sdram_dqm  <= wr_mask;
        ld_cnt        <= ld_cnt - 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (init_end && wr_en) begin
            ptr <= wr_addr;
            rem <= wr_bst_len;
            if (wr_bst_len == '0) begin
              state  <= ST_END;
              wr_end <= 1'b1;
            end else begin
              state         <= ST_ACT;
              wr_busy       <= 1'b1;
              seg           <= in_seg;
              ld_cnt        <= in_seg;
              wr_sdram_cmd  <= CMD_ACT;
              wr_sdram_bank <= in_bank;
              wr_sdram_addr <= in_row;
            end
          end
        end

        ST_ACT, ST_TRCD: begin
          if ((state == ST_ACT && T_RCD == 1) || (state == ST_TRCD && wt_done)) begin
            state         <= ST_WRITE;
            wr_sdram_cmd  <= CMD_WR;
            wr_sdram_bank <= ptr_bank;
            wr_sdram_addr <= ROW_W'(ptr_col);
          end else begin
            state <= ST_TRCD;
          end
        end

        // No ack this cycle means this is the last data beat; BST follows.
        ST_WRITE, ST_DATA: begin
          if (ld_cnt == '0) begin
            state        <= ST_TWR;
            wr_sdram_cmd <= CMD_BST;
          end else begin
            state <= ST_DATA;
          end
        end

        // Pointer/remaining advance as PRE issues; PRE itself still uses the old bank.
        ST_TWR: begin
          if (wt_done) begin
            state             <= ST_PRE;
            wr_sdram_cmd      <= CMD_PRE;
            wr_sdram_bank     <= ptr_bank;
            wr_sdram_addr     <= '0;
            wr_sdram_addr[10] <= 1'b1;
            ptr               <= ptr + ADDR_W'(seg);
            rem               <= rem - seg;
          end
        end

        ST_PRE, ST_TRP: begin
          if ((state == ST_PRE && T_RP == 1) || (state == ST_TRP && wt_done)) begin
            if (rem != '0) begin
              state         <= ST_ACT;
              seg           <= ptr_seg;
              ld_cnt        <= ptr_seg;
              wr_sdram_cmd  <= CMD_ACT;
              wr_sdram_bank <= ptr_bank;
              wr_sdram_addr <= ptr_row;
            end else begin
              state   <= ST_END;
              wr_busy <= 1'b0;
              wr_end  <= 1'b1;
            end
          end else begin
            state <= ST_TRP;
          end
        end

        ST_END:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_write_burst.sv
// Directed bench for sdram_write_burst: a table of bursts with hand-derived
// command/beat timelines, plus sequences for reset, init_end gating and a
// reset landing mid-burst.
module tb_sdram_write_burst;

  logic        clk = 1'b0;
  logic        wr_rst;
  logic        init_end;
  logic        wr_en;
  logic [23:0] wr_addr;
  logic [9:0]  wr_bst_len;
  logic [15:0] wr_data = 16'h0000;
  logic [1:0]  wr_mask = 2'b00;
  logic        wr_ack;
  logic        wr_busy;
  logic        wr_end;
  logic        wr_sdram_en;
  logic [3:0]  wr_sdram_cmd;
  logic [1:0]  wr_sdram_bank;
  logic [12:0] wr_sdram_addr;
  logic [15:0] wr_sdram_data;
  logic [1:0]  wr_sdram_dqm;

  always #5 clk = ~clk;

  sdram_write_burst #(
    .DATA_W (16),
    .BANK_W (2),
    .ROW_W  (13),
    .COL_W  (9),
    .LEN_W  (10),
    .T_RCD  (2),
    .T_WR   (2),
    .T_RP   (2)
  ) dut (
    .wr_clk        (clk),
    .wr_rst        (wr_rst),
    .init_end      (init_end),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_bst_len    (wr_bst_len),
    .wr_data       (wr_data),
    .wr_mask       (wr_mask),
    .wr_ack        (wr_ack),
    .wr_busy       (wr_busy),
    .wr_end        (wr_end),
    .wr_sdram_en   (wr_sdram_en),
    .wr_sdram_cmd  (wr_sdram_cmd),
    .wr_sdram_bank (wr_sdram_bank),
    .wr_sdram_addr (wr_sdram_addr),
    .wr_sdram_data (wr_sdram_data),
    .wr_sdram_dqm  (wr_sdram_dqm)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- monitor / beat-data source ----------------
  int          txn_id = 0;
  int          mask_beat = -1;
  int          seen_id = 0;
  int          cyc = 0;
  int          beat_i = 0;
  int          n_ack = 0;
  int          n_busy = 0;
  int          n_endp = 0;
  int          mon_end_cyc = -1;
  int          idle_bad = 0;
  logic        ack_now = 1'b0;
  logic [26:0] evq[$];   // {cmd, bank, addr, cycle}
  logic [25:0] bq[$];    // {cycle, dqm, data}

  always begin
    @(negedge clk);
    if (txn_id != seen_id) begin
      seen_id = txn_id;
      cyc = 0;
      evq.delete();
      bq.delete();
      n_ack = 0;
      n_busy = 0;
      n_endp = 0;
      mon_end_cyc = -1;
      idle_bad = 0;
      beat_i = 0;
      wr_data = 16'hA000;
      wr_mask = (mask_beat == 0) ? 2'b01 : 2'b00;
    end else begin
      cyc++;
    end
    if (wr_sdram_cmd != 4'b0111)
      evq.push_back({wr_sdram_cmd, wr_sdram_bank, wr_sdram_addr, cyc[7:0]});
    if (wr_sdram_en)
      bq.push_back({cyc[7:0], wr_sdram_dqm, wr_sdram_data});
    else if (wr_sdram_data != 16'h0000 || wr_sdram_dqm != 2'b11)
      idle_bad++;
    ack_now = wr_ack;
    if (wr_ack) n_ack++;
    if (wr_busy) n_busy++;
    if (wr_end) begin
      n_endp++;
      if (mon_end_cyc < 0) mon_end_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (ack_now) beat_i++;
    wr_data = 16'hA000 + 16'(beat_i);
    wr_mask = (beat_i == mask_beat) ? 2'b01 : 2'b00;
  end

  function automatic logic [26:0] ev_at(input int i);
    return (i < evq.size()) ? evq[i] : 27'h0;
  endfunction

  function automatic logic [25:0] bq_at(input int i);
    return (i < bq.size()) ? bq[i] : 26'h0;
  endfunction

  // ---------------- burst table ----------------
  typedef struct {
    logic [23:0]      addr;
    logic [9:0]       len;
    int               mask_beat;
    int               nseg;
    int               exp_end;
    logic [1:0][1:0]  bank;
    logic [1:0][12:0] row;
    logic [1:0][8:0]  col;
    logic [1:0][9:0]  seg;
  } rec_t;

  function automatic rec_t mk(input logic [23:0] a, input logic [9:0] l, input int mb,
                              input int ns, input int e,
                              input logic [1:0] b0, input logic [12:0] r0,
                              input logic [8:0] c0, input logic [9:0] s0,
                              input logic [1:0] b1, input logic [12:0] r1,
                              input logic [8:0] c1, input logic [9:0] s1);
    rec_t r;
    r.addr = a; r.len = l; r.mask_beat = mb; r.nseg = ns; r.exp_end = e;
    r.bank[0] = b0; r.row[0] = r0; r.col[0] = c0; r.seg[0] = s0;
    r.bank[1] = b1; r.row[1] = r1; r.col[1] = c1; r.seg[1] = s1;
    return r;
  endfunction

  rec_t vec[6];

  task automatic run_vec(input rec_t v, input int idx);
    int c;
    int s;
    int e;
    int k;
    logic [26:0] g;
    wr_addr = v.addr;
    wr_bst_len = v.len;
    mask_beat = v.mask_beat;
    wr_en = 1'b1;
    txn_id++;
    @(posedge clk); #1;
    wr_en = 1'b0;
    for (int i = 0; i < 200 && mon_end_cyc < 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    $display("vector %0d: addr=%h len=%0d", idx, v.addr, v.len);
    chk("end_cycle", mon_end_cyc, v.exp_end);
    chk("end_pulses", n_endp, 1);
    chk("busy_cycles", n_busy, (v.len == 0) ? 0 : v.exp_end - 1);
    chk("ack_count", n_ack, 32'(v.len));
    chk("beat_count", bq.size(), 32'(v.len));
    chk("event_count", evq.size(), 4 * v.nseg);
    chk("idle_bus", idle_bad, 0);
    c = 1; e = 0; k = 0;
    for (int j = 0; j < v.nseg; j++) begin
      s = int'(v.seg[j]);
      chk("act", ev_at(e), {4'b0011, v.bank[j], v.row[j], 8'(c)}); e++;
      chk("wr", ev_at(e), {4'b0100, v.bank[j], 4'b0000, v.col[j], 8'(c + 2)}); e++;
      g = ev_at(e);
      chk("bst", {g[26:23], g[7:0]}, {4'b0110, 8'(c + s + 2)}); e++;
      chk("pre", ev_at(e), {4'b0010, v.bank[j], 13'h0400, 8'(c + s + 4)}); e++;
      for (int i = 0; i < s; i++) begin
        chk("beat", bq_at(k), {8'(c + 2 + i), (k == v.mask_beat) ? 2'b01 : 2'b00,
                               16'hA000 + 16'(k)});
        k++;
      end
      c = c + s + 6;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    wr_rst = 1'b1;
    init_end = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_bst_len = '0;

    //            addr                      len  mb  ns end  b0    r0        c0       s0    b1    r1       c1     s1
    vec[0] = mk({2'd1, 13'd5,    9'd0},   10'd4, 2, 1, 11, 2'd1, 13'd5,    9'd0,   10'd4, 2'd0, 13'd0, 9'd0, 10'd0);
    vec[1] = mk({2'd0, 13'd7,    9'd508}, 10'd8, -1, 2, 21, 2'd0, 13'd7,    9'd508, 10'd4, 2'd0, 13'd8, 9'd0, 10'd4);
    vec[2] = mk({2'd1, 13'd3,    9'd5},   10'd0, -1, 0, 1,  2'd0, 13'd0,    9'd0,   10'd0, 2'd0, 13'd0, 9'd0, 10'd0);
    vec[3] = mk({2'd3, 13'd8191, 9'd511}, 10'd2, -1, 2, 15, 2'd3, 13'd8191, 9'd511, 10'd1, 2'd0, 13'd0, 9'd0, 10'd1);
    vec[4] = mk({2'd2, 13'd100,  9'd3},   10'd1, 0, 1, 8,  2'd2, 13'd100,  9'd3,   10'd1, 2'd0, 13'd0, 9'd0, 10'd0);
    vec[5] = mk({2'd0, 13'd8191, 9'd510}, 10'd5, 4, 2, 18, 2'd0, 13'd8191, 9'd510, 10'd2, 2'd1, 13'd0, 9'd0, 10'd3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", wr_sdram_cmd, 4'b0111);
    chk("rst_bank_addr", {wr_sdram_bank, wr_sdram_addr}, 15'h7fff);
    chk("rst_data_dqm", {wr_sdram_data, wr_sdram_dqm}, 18'h00003);
    chk("rst_flags", {wr_sdram_en, wr_ack, wr_busy, wr_end}, 4'b0000);
    @(posedge clk); #1;
    wr_rst = 1'b0;

    // Request while the SDRAM is not initialised must be ignored.
    wr_addr = {2'd0, 13'd1, 9'd0};
    wr_bst_len = 10'd4;
    wr_en = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wr_sdram_cmd != 4'b0111 || wr_busy || wr_ack || wr_end || wr_sdram_en) bad++;
    end
    chk("no_init_idle", bad, 0);
    @(posedge clk); #1;
    wr_en = 1'b0;
    init_end = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vec[i], i);

    // Reset landing in the middle of the data phase.
    wr_addr = {2'd1, 13'd20, 9'd0};
    wr_bst_len = 10'd8;
    mask_beat = -1;
    wr_en = 1'b1;
    txn_id++;
    @(posedge clk); #1;
    wr_en = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("beat_before_rst", {wr_sdram_en, wr_busy}, 2'b11);
    wr_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_cmd", wr_sdram_cmd, 4'b0111);
    chk("mid_rst_bank_addr", {wr_sdram_bank, wr_sdram_addr}, 15'h7fff);
    chk("mid_rst_data_dqm", {wr_sdram_data, wr_sdram_dqm}, 18'h00003);
    chk("mid_rst_flags", {wr_sdram_en, wr_ack, wr_busy, wr_end}, 4'b0000);
    @(posedge clk); #1;
    wr_rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (wr_end || wr_busy || wr_ack || wr_sdram_cmd != 4'b0111) bad++;
    end
    chk("after_rst_quiet", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
